// File: rtl/rv_pkg.sv
// Shared RV32I subset definitions: operation codes, opcode/funct3 values
// and encoder FSM states, common to the instruction encoder and decoder.
package rv_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_XORI = 4'd1,
        OP_ORI  = 4'd2,
        OP_ANDI = 4'd3,
        OP_ADD  = 4'd4,
        OP_XOR  = 4'd5,
        OP_OR   = 4'd6,
        OP_AND  = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9,
        OP_BNE  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    function automatic logic [2:0] funct3_of(op_e op);
        logic [2:0] f;
        f = 3'b000;
        case (op)
            OP_ADDI, OP_ADD: f = F3_ADD;
            OP_XORI, OP_XOR: f = F3_XOR;
            OP_ORI,  OP_OR:  f = F3_OR;
            OP_ANDI, OP_AND: f = F3_AND;
            OP_SW:           f = F3_SW;
            OP_BEQ:          f = F3_BEQ;
            OP_BNE:          f = F3_BNE;
            default:         f = 3'b000;
        endcase
        return f;
    endfunction

    // A 13-bit value fits a 12-bit signed field when its top two bits agree.
    function automatic logic fits12(logic [12:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of one abstract operation into an RV32I word,
// with a legality flag (unknown op, or bad immediate when checking is on).
module instr_pack
    import rv_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic [2:0] f3;

    assign f3 = funct3_of(op_e'(op));

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (op_e'(op))
            OP_ADDI, OP_XORI, OP_ORI, OP_ANDI: begin
                word = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
`ifdef INSTR_ENCODER_CHECK_EN
                legal = fits12(imm);
`endif
            end
            OP_ADD, OP_XOR, OP_OR, OP_AND: begin
                word = {7'b0, rs2, rs1, f3, rd, OPC_OP};
            end
            OP_SW: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
`ifdef INSTR_ENCODER_CHECK_EN
                legal = fits12(imm);
`endif
            end
            OP_BEQ, OP_BNE: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3,
                        imm[4:1], imm[11], OPC_BRANCH};
`ifdef INSTR_ENCODER_CHECK_EN
                // 13-bit even offsets always lie in -4096..4094
                legal = ~imm[0];
`endif
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

`ifndef INSTR_ENCODER_CHECK_EN
    logic unused_imm0;
    assign unused_imm0 = imm[0];
`endif

endmodule

// File: rtl/instr_encoder.sv
// Program-image encoder: streams operations into sequential instruction
// memory words. Optional immediate checking via INSTR_ENCODER_CHECK_EN.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DMAX = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] nxt_q, nxt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic [ADDR_W:0] count_inc;

    instr_pack u_pack (
        .op    (in_op),
        .rd    (in_rd),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .imm   (in_imm),
        .word  (word),
        .legal (legal)
    );

    assign accept    = in_valid & in_ready_q;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        nxt_d   = nxt_q;
        err_d   = err_q;
        count_d = count_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = nxt_q;
                        wdata_d = word;
                        nxt_d   = nxt_q + 1'b1;
                        count_d = count_inc;
                        if (in_last) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (count_inc == DMAX) begin
                            state_d = ST_FULL;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                // Restart: the write captured above still goes out.
                if (start) begin
                    state_d = ST_RUN;
                    nxt_d   = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_IDLE, ST_FULL, ST_ERR: begin
                if (start) begin
                    state_d = ST_RUN;
                    nxt_d   = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE;
            nxt_q      <= BASE;
            wdata_q    <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            nxt_q      <= nxt_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected writes go to a queue when an
// operation is driven and are checked when imem_we appears.
module tb_instr_encoder;
    import rv_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [12:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, err;
    logic [AW:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          last;
    } exp_t;

    exp_t sb[$];

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    // Write monitor
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_write obs=%h@%0d exp=none",
                       imem_wdata, imem_addr);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                assert ({imem_addr, imem_wdata, done} === e) else begin
                    n_err++;
                    $error("FAIL write obs=%h@%0d done=%b exp=%h@%0d done=%b",
                           imem_wdata, imem_addr, done, e.data, e.addr, e.last);
                end
            end
        end else if (!rst) begin
            n_cmp++;
            assert (done === 1'b0) else begin
                n_err++;
                $error("FAIL done_without_we obs=%b exp=0", done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [3:0] op, logic [4:0] rd, logic [4:0] r1,
                         logic [4:0] r2, logic [12:0] imm, logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = r1;
        in_rs2   = r2;
        in_imm   = imm;
        in_last  = last;
    endtask

    task automatic expect_wr(logic [AW-1:0] a, logic [31:0] d, logic l);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_last = 1'b0;
        tick(); tick();
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_we", {31'b0, imem_we}, 0);
        chk("rst_addr", {24'b0, imem_addr}, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_count", {23'b0, count}, 0);
        rst = 1'b0;
        tick();

        // Single ADDI program
        do_start();
        chk("t1_ready", {31'b0, in_ready}, 1);
        chk("t1_busy", {31'b0, busy}, 1);
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        expect_wr(0, 32'h00500093, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t1_ready_drop", {31'b0, in_ready}, 0);
        tick();
        chk("t1_busy_drop", {31'b0, busy}, 0);
        chk("t1_count", {23'b0, count}, 1);

        // Back-to-back ADD, SW, BNE
        do_start();
        drive(OP_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        expect_wr(0, 32'h002081B3, 1'b0);
        tick();
        drive(OP_SW, 5'd0, 5'd0, 5'd3, 13'd8, 1'b0);
        expect_wr(1, 32'h00302423, 1'b0);
        tick();
        drive(OP_BNE, 5'd0, 5'd1, 5'd2, -13'sd8, 1'b1);
        expect_wr(2, 32'hFE209CE3, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2_count", {23'b0, count}, 3);
        chk("t2_busy", {31'b0, busy}, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // Overflow DEPTH=4 with five ops, no last
        do_start();
        for (int i = 0; i < 5; i++) begin
            drive(OP_XORI, 5'(i + 1), 5'd2, 5'd0, 13'(i), 1'b0);
            if (i < 4)
                expect_wr(AW'(i),
                          {12'(i), 5'd2, 3'b100, 5'(i + 1), 7'b0010011},
                          1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t3_ready", {31'b0, in_ready}, 0);
        chk("t3_err", {31'b0, err}, 1);
        chk("t3_busy", {31'b0, busy}, 1);
        chk("t3_count", {23'b0, count}, 4);
        chk("t3_sb_empty", sb.size(), 0);
        do_start();
        chk("t3_err_clr", {31'b0, err}, 0);
        chk("t3_ready_back", {31'b0, in_ready}, 1);
        chk("t3_count_clr", {23'b0, count}, 0);

        // Unknown op
        drive(4'hF, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_err", {31'b0, err}, 1);
        chk("t4_ready", {31'b0, in_ready}, 0);
        chk("t4_busy", {31'b0, busy}, 1);
        chk("t4_count", {23'b0, count}, 0);
        do_start();
        chk("t4_err_clr", {31'b0, err}, 0);
        chk("t4_ready_back", {31'b0, in_ready}, 1);

        // Out-of-range ADDI immediate
        drive(OP_ADDI, 5'd2, 5'd0, 5'd0, 13'd3000, 1'b1);
`ifndef INSTR_ENCODER_CHECK_EN
        expect_wr(0, 32'hBB800113, 1'b1);
`endif
        tick();
        in_valid = 1'b0;
        tick();
`ifdef INSTR_ENCODER_CHECK_EN
        chk("t5_err", {31'b0, err}, 1);
        chk("t5_count", {23'b0, count}, 0);
`else
        chk("t5_err", {31'b0, err}, 0);
        chk("t5_count", {23'b0, count}, 1);
`endif
        chk("t5_sb_empty", sb.size(), 0);

        // Reset in the same cycle as an accept
        do_start();
        drive(OP_ORI, 5'd4, 5'd4, 5'd0, 13'd7, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("t6_we", {31'b0, imem_we}, 0);
        chk("t6_count", {23'b0, count}, 0);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_ready", {31'b0, in_ready}, 0);
        tick();
        tick();
        chk("end_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
